// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: command codes,
// sequencer state encoding and the {hi, lo} result payload.
package mdu_pkg;

  localparam int unsigned XLEN = 32;

  // MDUOp command encodings (3-bit field from E-stage decode)
  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // 64-bit multiply/divide result, split into its HI and LO halves
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } mdu_res_t;

endpackage : mdu_pkg

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op_i     - command code (only MULT/MULTU/DIV/DIVU produce a new result)
//   src_a_i  - rs operand (multiplicand / dividend)
//   src_b_i  - rt operand (multiplier / divisor)
//   hi_i     - current architectural HI, returned on divide-by-zero
//   lo_i     - current architectural LO, returned on divide-by-zero
//   res_o    - {hi, lo} result
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output mdu_res_t        res_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] NEG_ONE = {XLEN{1'b1}};

  logic signed [2*XLEN-1:0] mul_s;
  logic        [2*XLEN-1:0] mul_u;
  logic signed [XLEN-1:0]   quo_s;
  logic signed [XLEN-1:0]   rem_s;
  logic        [XLEN-1:0]   quo_u;
  logic        [XLEN-1:0]   rem_u;
  logic                     div_zero;
  logic                     div_ovf;

  // Raw products and quotients for every op; the result mux picks one
  always_comb begin
    mul_s    = $signed({{XLEN{src_a_i[XLEN-1]}}, src_a_i}) *
               $signed({{XLEN{src_b_i[XLEN-1]}}, src_b_i});
    mul_u    = {{XLEN{1'b0}}, src_a_i} * {{XLEN{1'b0}}, src_b_i};
    div_zero = (src_b_i == '0);
    div_ovf  = (src_a_i == INT_MIN) && (src_b_i == NEG_ONE);
    quo_s    = $signed(src_a_i) / $signed(src_b_i);
    rem_s    = $signed(src_a_i) % $signed(src_b_i);
    quo_u    = src_a_i / src_b_i;
    rem_u    = src_a_i % src_b_i;
  end

  // Result select; divide-by-zero leaves HI/LO as they are, and the
  // INT_MIN / -1 overflow wraps to INT_MIN with a zero remainder
  always_comb begin
    res_o.hi = hi_i;
    res_o.lo = lo_i;
    case (op_i)
      MULT: begin
        res_o.hi = mul_s[2*XLEN-1:XLEN];
        res_o.lo = mul_s[XLEN-1:0];
      end
      MULTU: begin
        res_o.hi = mul_u[2*XLEN-1:XLEN];
        res_o.lo = mul_u[XLEN-1:0];
      end
      DIV: begin
        if (div_ovf) begin
          res_o.hi = '0;
          res_o.lo = INT_MIN;
        end else if (!div_zero) begin
          res_o.hi = rem_s;
          res_o.lo = quo_s;
        end
      end
      DIVU: begin
        if (!div_zero) begin
          res_o.hi = rem_u;
          res_o.lo = quo_u;
        end
      end
      default: ;
    endcase
  end

endmodule : mdu_arith

// File: rtl/e_mdu_ctrl.sv
// E-stage multi-cycle multiply/divide sequencer. Latches the result of a
// MULT/MULTU/DIV/DIVU at issue, holds Busy for a fixed latency, then commits
// it to HI/LO. MTHI/MTLO write HI/LO directly with zero latency.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-low
//   Start  - command valid this cycle
//   MDUOp  - command code (mdu_pkg::mdu_op_e)
//   SrcA   - rs operand
//   SrcB   - rt operand
//   Busy   - registered, high while a mult/div is in flight
//   HI/LO  - registered architectural HI/LO
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      MDUOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic            busy_q,  busy_d;
  logic [XLEN-1:0] hi_q,    hi_d;
  logic [XLEN-1:0] lo_q,    lo_d;
  mdu_res_t        pend_q,  pend_d;
  mdu_res_t        arith_res;

  mdu_arith u_arith (
    .op_i    (MDUOp),
    .src_a_i (SrcA),
    .src_b_i (SrcB),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .res_o   (arith_res)
  );

  // Next-state: issue in IDLE, count down in RUN, commit on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (MDUOp)
            MULT, MULTU: begin
              pend_d  = arith_res;
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            DIV, DIVU: begin
              pend_d  = arith_res;
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            MTHI:    hi_d = SrcA;
            MTLO:    lo_d = SrcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Start is ignored here; the hazard unit never issues one
        if (cnt_q == '0) begin
          hi_d    = pend_q.hi;
          lo_d    = pend_q.lo;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight op without writing HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule : e_mdu_ctrl
